// File: rtl/cnn_params_pkg.sv
// Shared widths, raster limits, fixed 3x3 kernels and the ReLU/saturation helper
// for the CNN streaming front end.
package cnn_params_pkg;
  localparam int X_RES_MAX = 600;
  localparam int Y_RES_MAX = 800;
  localparam int COORD_W   = 10;
  localparam int PIXEL_W   = 9;
  localparam int WEIGHT_W  = 10;
  localparam int RECT_W    = 9;
  localparam int ACC_W     = 24;
  localparam int FRAC_W    = 8;
  localparam int PROD_W    = PIXEL_W + 1 + WEIGHT_W;
  localparam logic [RECT_W-1:0] RECT_MAX = 9'd511;

  typedef logic [PIXEL_W-1:0] pixel_t;
  // Tap index is row*3+col; row 0 is y-2, col 0 is x-2, tap 8 is the newest pixel.
  typedef logic [8:0][PIXEL_W-1:0]  window_t;
  typedef logic [8:0][WEIGHT_W-1:0] kernel_t;

  localparam kernel_t KERNEL_BOX = {9{10'h020}};
  localparam kernel_t KERNEL_LAP = {10'h000, 10'h3C0, 10'h000,
                                    10'h3C0, 10'h100, 10'h3C0,
                                    10'h000, 10'h3C0, 10'h000};

  function automatic logic [RECT_W-1:0] relu_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] shifted;
    logic [RECT_W-1:0]       result;
    shifted = acc >>> FRAC_W;
    if (shifted[ACC_W-1]) begin
      result = {RECT_W{1'b0}};
    end else if (|shifted[ACC_W-2:RECT_W]) begin
      result = RECT_MAX;
    end else begin
      result = shifted[RECT_W-1:0];
    end
    return result;
  endfunction
endpackage

// File: rtl/conv3x3_relu.sv
// One fixed-kernel 3x3 convolution channel: multiply, sum, shift, ReLU, saturate.
// Three register stages from taps to rect.
module conv3x3_relu
  import cnn_params_pkg::*;
#(
  parameter kernel_t WEIGHTS = KERNEL_BOX
) (
  input  logic              clock,
  input  logic              reset,
  input  window_t           taps,
  output logic [RECT_W-1:0] rect
);
  logic signed [PROD_W-1:0] prod_d [9];
  logic signed [PROD_W-1:0] prod_q [9];
  logic signed [ACC_W-1:0]  sum_d, sum_q;
  logic [RECT_W-1:0]        rect_d, rect_q;

  // Products, accumulation and output conditioning for the next register stage.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      prod_d[i] = $signed({1'b0, taps[i]}) * $signed(WEIGHTS[i]);
    end
    sum_d = {ACC_W{1'b0}};
    for (int i = 0; i < 9; i++) begin
      sum_d = sum_d + {{(ACC_W-PROD_W){prod_q[i][PROD_W-1]}}, prod_q[i]};
    end
    rect_d = relu_sat(sum_q);
  end

  // Pipeline registers, cleared by synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) begin
        prod_q[i] <= {PROD_W{1'b0}};
      end
      sum_q  <= {ACC_W{1'b0}};
      rect_q <= {RECT_W{1'b0}};
    end else begin
      for (int i = 0; i < 9; i++) begin
        prod_q[i] <= prod_d[i];
      end
      sum_q  <= sum_d;
      rect_q <= rect_d;
    end
  end

  assign rect = rect_q;
endmodule

// File: rtl/cnn_pipeline_top.sv
// Streaming CNN front end: two line buffers and a 3x3 window feeding a box
// channel (rect0) and a Laplacian channel (rect1).
module cnn_pipeline_top
  import cnn_params_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [COORD_W-1:0] screen_x_pos,
  input  logic [COORD_W-1:0] screen_y_pos,
  input  logic [PIXEL_W-1:0] test_pixel,
  output logic [RECT_W-1:0]  rect0,
  output logic [RECT_W-1:0]  rect1
);
  localparam int LINE_LEN = X_RES_MAX + 1;
  typedef logic [2:0][PIXEL_W-1:0] column_t;

  pixel_t     line_y1_q [LINE_LEN];
  pixel_t     line_y2_q [LINE_LEN];
  column_t    col_x_s;
  column_t    col_xm1_q, col_xm1_d;
  column_t    col_xm2_q, col_xm2_d;
  logic [1:0] rows_started_q, rows_started_d;
  logic       win_valid_s;
  window_t    taps_s;

  // Assemble the current window and gate it to zero until rows are trustworthy.
  always_comb begin
    col_x_s[0] = line_y2_q[screen_x_pos];
    col_x_s[1] = line_y1_q[screen_x_pos];
    col_x_s[2] = test_pixel;
    col_xm1_d  = col_x_s;
    col_xm2_d  = col_xm1_q;

    if (screen_x_pos == {COORD_W{1'b0}} && rows_started_q != 2'd3) begin
      rows_started_d = rows_started_q + 2'd1;
    end else begin
      rows_started_d = rows_started_q;
    end

    win_valid_s = (screen_x_pos >= COORD_W'(2)) && (screen_y_pos >= COORD_W'(2)) &&
                  (rows_started_q == 2'd3);

    taps_s = {9*PIXEL_W{1'b0}};
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (win_valid_s) begin
          case (c)
            0:       taps_s[r*3+c] = col_xm2_q[r];
            1:       taps_s[r*3+c] = col_xm1_q[r];
            default: taps_s[r*3+c] = col_x_s[r];
          endcase
        end else begin
          taps_s[r*3+c] = {PIXEL_W{1'b0}};
        end
      end
    end
  end

  // Line-buffer RAMs; contents survive reset, row y-1 ages into row y-2.
  always_ff @(posedge clock) begin
    if (screen_x_pos <= COORD_W'(X_RES_MAX)) begin
      line_y1_q[screen_x_pos] <= test_pixel;
      line_y2_q[screen_x_pos] <= line_y1_q[screen_x_pos];
    end
  end

  // Window columns and the warm-up row counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      col_xm1_q      <= {3*PIXEL_W{1'b0}};
      col_xm2_q      <= {3*PIXEL_W{1'b0}};
      rows_started_q <= 2'd0;
    end else begin
      col_xm1_q      <= col_xm1_d;
      col_xm2_q      <= col_xm2_d;
      rows_started_q <= rows_started_d;
    end
  end

  conv3x3_relu #(.WEIGHTS(KERNEL_BOX)) u_conv_box (
    .clock (clock),
    .reset (reset),
    .taps  (taps_s),
    .rect  (rect0)
  );

  conv3x3_relu #(.WEIGHTS(KERNEL_LAP)) u_conv_lap (
    .clock (clock),
    .reset (reset),
    .taps  (taps_s),
    .rect  (rect1)
  );
endmodule

// File: tb/tb_cnn_pipeline_top.sv
// Scoreboard bench for cnn_pipeline_top: directed raster scans with hand-computed
// expectations queued per pixel and checked three clocks later by a monitor.
module tb_cnn_pipeline_top;
  import cnn_params_pkg::*;

  localparam int M_CONST = 0;
  localparam int M_SAT   = 1;
  localparam int M_IMP   = 2;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [COORD_W-1:0] screen_x_pos = '0;
  logic [COORD_W-1:0] screen_y_pos = '0;
  logic [PIXEL_W-1:0] test_pixel = '0;
  logic [RECT_W-1:0]  rect0;
  logic [RECT_W-1:0]  rect1;

  typedef struct {
    int         due;
    int         x;
    int         y;
    logic [8:0] e0;
    logic [8:0] e1;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_bad  = 0;
  int   rs_m   = 0;

  cnn_pipeline_top dut (
    .clock        (clock),
    .reset        (reset),
    .screen_x_pos (screen_x_pos),
    .screen_y_pos (screen_y_pos),
    .test_pixel   (test_pixel),
    .rect0        (rect0),
    .rect1        (rect1)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: pop every entry whose output is due this cycle and compare.
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if (rect0 !== e.e0 || rect1 !== e.e1 || e.due != cyc) begin
        n_bad++;
        $display("FAIL rect at (%0d,%0d) cyc %0d: got rect0=%h rect1=%h, expected rect0=%h rect1=%h",
                 e.x, e.y, cyc, rect0, rect1, e.e0, e.e1);
      end
    end
  end

  function automatic logic [8:0] pix(int mode, int xi, int yi);
    case (mode)
      M_CONST: return 9'h040;
      M_SAT:   return 9'h1FF;
      M_IMP:   return (xi == 10 && yi == 10) ? 9'h100 : 9'h000;
      default: return 9'h000;
    endcase
  endfunction

  // Hand-computed results for a valid window whose bottom-right pixel is (xi,yi).
  function automatic logic [17:0] expect_valid(int mode, int xi, int yi);
    logic [8:0] e0, e1;
    case (mode)
      M_CONST: begin e0 = 9'd72;  e1 = 9'd0; end
      M_SAT:   begin e0 = 9'h1FF; e1 = 9'd0; end
      M_IMP: begin
        e0 = (xi >= 10 && xi <= 12 && yi >= 10 && yi <= 12) ? 9'h020 : 9'h000;
        e1 = (xi == 11 && yi == 11) ? 9'h100 : 9'h000;
      end
      default: begin e0 = 9'd0; e1 = 9'd0; end
    endcase
    return {e0, e1};
  endfunction

  task automatic drive(int mode, int xi, int yi, bit rst);
    exp_t        e;
    logic [17:0] v;
    reset        = rst;
    screen_x_pos = xi[COORD_W-1:0];
    screen_y_pos = yi[COORD_W-1:0];
    test_pixel   = pix(mode, xi, yi);
    if (rst) begin
      foreach (sb[i]) begin
        if (sb[i].due > cyc) begin
          sb[i].e0 = 9'd0;
          sb[i].e1 = 9'd0;
        end
      end
    end
    v = (!rst && xi >= 2 && yi >= 2 && rs_m == 3) ? expect_valid(mode, xi, yi) : 18'd0;
    if (rst) rs_m = 0;
    else if (xi == 0 && rs_m < 3) rs_m++;
    e.due = cyc + 3;
    e.x   = xi;
    e.y   = yi;
    e.e0  = v[17:9];
    e.e1  = v[8:0];
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic row(int mode, int yi, int rst_x);
    for (int xi = 0; xi <= X_RES_MAX; xi++) begin
      drive(mode, xi, yi, xi == rst_x);
    end
  endtask

  task automatic short_reset(int mode);
    for (int i = 0; i < 3; i++) drive(mode, 0, 0, 1'b1);
  endtask

  initial begin
    @(posedge clock);
    #1;
    // Long reset with a running raster: outputs must stay zero.
    for (int i = 0; i < 1000; i++) drive(M_CONST, i % 601, i / 601, 1'b1);
    // Constant 0.25: warm-up, left border, then y wrap 800 -> 0 -> 2.
    row(M_CONST, 798, -1);
    row(M_CONST, 799, -1);
    row(M_CONST, 800, -1);
    row(M_CONST, 0, -1);
    row(M_CONST, 1, -1);
    row(M_CONST, 2, -1);
    // Saturation with all-ones pixels.
    short_reset(M_SAT);
    for (int yi = 5; yi <= 8; yi++) row(M_SAT, yi, -1);
    // Single impulse at (10,10).
    short_reset(M_IMP);
    for (int yi = 7; yi <= 12; yi++) row(M_IMP, yi, -1);
    // One-cycle reset mid-frame at (300,400); valid again on row 403.
    short_reset(M_CONST);
    for (int yi = 397; yi <= 403; yi++) row(M_CONST, yi, (yi == 400) ? 300 : -1);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clock);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d results still pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
